// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
// Holds the controller state type and the default operand width.
// Build option: SERIAL_ADD_OVF_EN (signed-overflow output) is handled in the users of this package.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
// Signals:
//   in_valid/in_ready : operand bundle handshake (a, b, cin)
//   a, b              : WIDTH-bit operands
//   cin               : carry-in
//   out_valid/out_ready : result handshake (sum, cout[, ovf])
//   sum               : WIDTH-bit result, cout : carry out of MSB
//   ovf               : signed overflow, only with SERIAL_ADD_OVF_EN
// Modports: master = producer/consumer side, slave = the adder.
interface serial_adder_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_adder_fulladder.sv
// rtl/serial_adder_fulladder.sv - single-bit full adder cell used as the serial slice
// Ports:
//   a, b : addend bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-adder slice, LSB first
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_adder_if.slave (operand handshake in, result handshake out)
// Build option: SERIAL_ADD_OVF_EN adds the signed overflow output bus.ovf.
// Latency: result valid WIDTH cycles after operand acceptance.
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_slice_s;
  logic             w_slice_c;
  logic [WIDTH-1:0] w_sum_next;

  fulladder u_slice (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .c  (r_carry),
    .s  (w_slice_s),
    .co (w_slice_c)
  );

  // New slice bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
  assign w_sum_next = {w_slice_s, r_sum_sr[WIDTH-1:1]};
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_last     = (r_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs depend only on the registered state, never on
  // in_valid/out_ready directly.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_sum_sr <= w_sum_next;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= w_slice_c;
          if (w_last) begin
            // Publish the result on the final slice edge; counter stays put
            // so it never wraps inside an operation.
            r_sum  <= w_sum_next;
            r_cout <= w_slice_c;
`ifdef SERIAL_ADD_OVF_EN
            // r_carry is the carry into the MSB during the final slice.
            r_ovf  <= r_carry ^ w_slice_c;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  import serial_add_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One full transaction: accept, count latency, check result, optional
  // back-pressure hold, optional in_valid poke while shifting.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic [7:0] es, input logic ec,
                        input logic eo, input int hold, input bit poke);
    int lat;
    logic [7:0] s_hold;
    logic       c_hold;
    @(posedge clk); #1;
    chk({tag, "_in_ready_before"}, bus.in_ready, 1);
    bus.a         = ai;
    bus.b         = bi;
    bus.cin       = ci;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'hEE;
    bus.b        = 8'h77;
    bus.cin      = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (poke) begin
        chk({tag, "_in_ready_shift"}, bus.in_ready, 0);
        bus.in_valid = (lat == 2);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, eo);
`else
    if (eo === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
    s_hold = bus.sum;
    c_hold = bus.cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_sum"}, bus.sum, s_hold);
      chk({tag, "_hold_cout"}, bus.cout, c_hold);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_after"}, bus.out_valid, 0);
    chk({tag, "_in_ready_after"}, bus.in_ready, 1);
    chk({tag, "_sum_kept"}, bus.sum, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    rst = 1'b0;

    run_op("v5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
    run_op("vff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op("v7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    run_op("v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    run_op("v00_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b1);
    run_op("bp_12_34", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5, 1'b0);

    // Reset during the 4th SHIFT cycle discards the operation.
    @(posedge clk); #1;
    bus.a        = 8'h33;
    bus.b        = 8'h44;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_cout", bus.cout, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("v10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then streams them LSB-first through one full-adder bit slice, one bit per clock. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly upstream of the fulladder cell: it feeds that cell and registers its sum/carry each cycle. This trades WIDTH cycles of latency for a single adder slice.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle (a, b, cin) valid.
- in_ready  output  1  block can accept an operand bundle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state = IDLE, sum = 0, cout = 0, ovf = 0, out_valid = 0, bit counter = 0.
- in_ready is exactly (state == IDLE), so it reads 1 out of reset.
- **IDLE:** on in_valid & in_ready at an edge:
  - latch a and b into shift registers;
  - load carry_q <= cin;
  - clear the counter;
  - go to SHIFT.
- **SHIFT:** the slice adds a_sr[0], b_sr[0] and carry_q.
  - Slice sum shifts into the MSB of sum_sr.
  - a_sr and b_sr shift right by one; carry_q <= slice carry.
  - The counter increments.
  - After the WIDTH-th SHIFT cycle (counter == WIDTH-1), go to DONE.
  - On that same edge, sum <= the final sum_sr and cout <= the final slice carry.
- **DONE:** out_valid = 1; sum and cout are held stable.
  - On out_ready, go to IDLE.
  - While out_ready is low, hold DONE indefinitely with outputs unchanged.
- in_valid outside IDLE is ignored; the pending bundle is not captured.
- sum and cout keep their last value after leaving DONE until the next result overwrites them.
- Arithmetic: {cout, sum} == a + b + cin with a (WIDTH+1)-bit result. No other width extension.
- Reset mid-operation (any state): return immediately to reset values. The partial result is discarded and nothing is emitted.

## Timing
- Operand handshake at edge T0:
  - SHIFT cycles occupy T0+1 .. T0+WIDTH;
  - out_valid rises after edge T0+WIDTH, i.e. WIDTH cycles after acceptance.
- With out_ready held high, the result handshake completes at edge T0+WIDTH+1.
  - in_ready is high again in the following cycle.
  - Minimum initiation interval: WIDTH+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Bit counter width: $clog2(WIDTH); it does not wrap within one operation.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - ovf output exists;
  - ovf = carry into MSB XOR carry out of MSB, captured in the final SHIFT cycle;
  - ovf follows the same hold and reset rules as cout.
- Undefined: no ovf port and no related logic.

## Structure
- Shared package serial_add_pkg holds:
  - state enum type (IDLE, SHIFT, DONE);
  - default WIDTH constant.
- One sub-module: the existing fulladder cell instantiated as the bit slice (a = a_sr[0], b = b_sr[0], c = carry_q). No other arithmetic in the block.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, cin=0; out_ready=1 -> sum=0x96, cout=0. out_valid rises exactly 8 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. in_valid pulsed during SHIFT is ignored (in_ready=0 throughout).
- Back-pressure: out_ready low for 5 cycles in DONE -> out_valid, sum and cout held constant. On release, in_ready=1 the next cycle.
- rst asserted in the 4th SHIFT cycle -> out_valid=0, sum=0, in_ready=1 immediately. A following 0x10+0x20 returns 0x30.
